// File: rtl/wb_mem_slave_bridge_if.sv
// Wishbone classic bus bundle between an interconnect master and a memory slave bridge.
interface wb_mem_slave_bridge_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic [ADDR_W-1:0] wb_addr_i;
    logic [DATA_W-1:0] wb_data_i;
    logic [DATA_W-1:0] wb_data_o;
    logic              wb_we_i;
    logic              wb_stb_i;
    logic              wb_cyc_i;
    logic [SEL_W-1:0]  wb_sel_i;
    logic              wb_ack_o;
    logic              wb_err_o;

    modport slave (
        input  wb_addr_i, wb_data_i, wb_we_i, wb_stb_i, wb_cyc_i, wb_sel_i,
        output wb_data_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_addr_i, wb_data_i, wb_we_i, wb_stb_i, wb_cyc_i, wb_sel_i,
        input  wb_data_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_mem_slave_bridge.sv
// Wishbone classic slave to synchronous RAM bridge with registered ack/read data.
// Define WB_SLV_ADDR_ERR_EN to enable the address-window check and the error response.
module wb_mem_slave_bridge #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                MEM_AW      = 10,
    parameter int                MEM_LATENCY = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] ADDR_MASK   = 32'hFFFF_F000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    wb_mem_slave_bridge_if.slave  wb,
    output logic [MEM_AW-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic                  mem_we_o,
    output logic                  mem_en_o,
    output logic [DATA_W/8-1:0]   mem_sel_o
);
    // state  | meaning
    // S_IDLE | waiting for cyc & stb
    // S_REQ  | memory access issued (en, we)
    // S_WAIT | read latency countdown, capture on terminal count
    // S_ACK  | one-cycle ack
    // S_ERR  | one-cycle err for out-of-window access (optional)

    localparam int         SEL_W    = DATA_W / 8;
    localparam int         OFS      = $clog2(SEL_W);
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ACK
`ifdef WB_SLV_ADDR_ERR_EN
        , S_ERR
`endif
    } state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic               ack_q, ack_nxt;
    logic               en_nxt, we_nxt;
    logic [MEM_AW-1:0]  addr_nxt;
    logic [DATA_W-1:0]  wdata_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic [DATA_W-1:0]  rdata_q, rdata_nxt;
    logic               req, hit;

    assign req = wb.wb_cyc_i & wb.wb_stb_i;

`ifdef WB_SLV_ADDR_ERR_EN
    logic err_q, err_nxt;

    assign hit = ((wb.wb_addr_i & ADDR_MASK) == BASE_ADDR);
    assign wb.wb_err_o = err_q & req;

    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_nxt;
    end
`else
    logic unused_window;

    assign hit = 1'b1;
    assign unused_window = ^{wb.wb_addr_i, BASE_ADDR, ADDR_MASK};
    assign wb.wb_err_o = 1'b0;
`endif

    // Ack is qualified by req so an abandoned cycle never sees a stray ack.
    assign wb.wb_ack_o  = ack_q & req;
    assign wb.wb_data_o = rdata_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ack_nxt   = 1'b0;
        en_nxt    = 1'b0;
        we_nxt    = 1'b0;
        addr_nxt  = mem_addr_o;
        wdata_nxt = mem_wdata_o;
        sel_nxt   = mem_sel_o;
        rdata_nxt = rdata_q;
`ifdef WB_SLV_ADDR_ERR_EN
        err_nxt   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (req && hit) begin
                    state_nxt = S_REQ;
                    en_nxt    = 1'b1;
                    we_nxt    = wb.wb_we_i;
                    addr_nxt  = wb.wb_addr_i[OFS +: MEM_AW];
                    wdata_nxt = wb.wb_data_i;
                    sel_nxt   = wb.wb_sel_i;
                end
`ifdef WB_SLV_ADDR_ERR_EN
                else if (req) begin
                    state_nxt = S_ERR;
                    err_nxt   = 1'b1;
                end
`endif
            end
            S_REQ: begin
                if (!req) begin
                    state_nxt = S_IDLE;
                end else if (mem_we_o) begin
                    state_nxt = S_ACK;
                    ack_nxt   = 1'b1;
                end else begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = LAT_LOAD;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_nxt = S_IDLE;
                end else if (cnt == 4'd0) begin
                    state_nxt = S_ACK;
                    ack_nxt   = 1'b1;
                    rdata_nxt = mem_rdata_i;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_ACK: state_nxt = S_IDLE;
`ifdef WB_SLV_ADDR_ERR_EN
            S_ERR: state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            ack_q       <= 1'b0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_sel_o   <= '0;
            rdata_q     <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ack_q       <= ack_nxt;
            mem_en_o    <= en_nxt;
            mem_we_o    <= we_nxt;
            mem_addr_o  <= addr_nxt;
            mem_wdata_o <= wdata_nxt;
            mem_sel_o   <= sel_nxt;
            rdata_q     <= rdata_nxt;
        end
    end
endmodule

// File: doc/wb_mem_slave_bridge.md
Name: wb_mem_slave_bridge

Overview:
Parametrised successor to the single-cycle Wishbone slave adapter. Bridges a Wishbone classic slave port to a synchronous RAM/IP core with configurable data width, read latency and address window. Read data and ack are registered. Transactions aborted by the master are handled cleanly. Sits between the NoC/Wishbone interconnect and each on-chip memory or peripheral core.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8, 8..128.
- ADDR_W, 32, Wishbone byte-address width.
- MEM_AW, 10, memory word-address width.
- MEM_LATENCY, 1, RAM read latency in cycles; 1..15.
- BASE_ADDR, 32'h0000_0000, window base; compared under ADDR_MASK.
- ADDR_MASK, 32'hFFFF_F000, mask for window decode.
- SEL_W (derived, not overridable), DATA_W/8.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- wb_addr_i  in  ADDR_W  byte address.
- wb_data_i  in  DATA_W  write data.
- wb_data_o  out  DATA_W  registered read data.
- wb_we_i  in  1  1 = write.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_sel_i  in  SEL_W  byte select.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  error; see Optional Feature.
- mem_addr_o  out  MEM_AW  word address = wb_addr_i[log2(SEL_W) +: MEM_AW].
- mem_wdata_o  out  DATA_W  registered write data.
- mem_rdata_i  in  DATA_W  RAM read data.
- mem_we_o  out  1  write enable.
- mem_en_o  out  1  chip enable.
- mem_sel_o  out  SEL_W  byte enables.

Behaviour:
- req = wb_cyc_i & wb_stb_i. hit = ((wb_addr_i & ADDR_MASK) == BASE_ADDR).
- Reset: state = IDLE. wb_ack_o, wb_err_o, mem_en_o and mem_we_o = 0. wb_data_o, mem_addr_o, mem_wdata_o and mem_sel_o = 0. Latency counter = 0.
- All mem_* outputs are registered. They are captured from the Wishbone inputs on the IDLE->REQ transition and held until IDLE.
- FSM states: IDLE, REQ, WAIT, ACK, ERR.
- IDLE: if req & hit, go to REQ. If req & !hit (ERR path compiled in), go to ERR. Otherwise stay.
- REQ: one cycle. mem_en_o = 1, and mem_we_o = the latched wb_we_i.
  - Write: go to ACK.
  - Read: load counter with MEM_LATENCY-1, then go to WAIT.
- WAIT: counter decrements each cycle. When counter == 0, capture mem_rdata_i into wb_data_o and go to ACK. mem_en_o = 0 during WAIT.
- ACK: wb_ack_o = 1 for exactly one cycle, then go to IDLE.
- ERR: wb_err_o = 1 for exactly one cycle, then go to IDLE. No memory access occurs.
- Timing, request first seen in cycle 0:
  - Write: mem_en/we in cycle 1, ack in cycle 2.
  - Read: mem_en in cycle 1, data captured at the end of cycle 1+MEM_LATENCY, ack in cycle 2+MEM_LATENCY.
- Ack and err are never asserted together. Ack/err is never asserted while req = 0.
- Abort: if req drops in REQ or WAIT, return to IDLE next cycle with no ack/err. wb_data_o holds its previous value. A write already issued in REQ is not undone.
- Back-to-back: req held high after ACK starts a new transaction from IDLE. Maximum rate is one write per 3 cycles.
- wb_data_o is updated only on a read capture. It is unchanged by writes, errors and aborts.
- rst_i asserted mid-transaction: next cycle is IDLE with all outputs at reset values. No ack is issued.

Optional Feature:
- Macro: WB_SLV_ADDR_ERR_EN.
- Defined: out-of-window requests take the ERR path and get a one-cycle wb_err_o.
- Undefined: no window check; every request is treated as hit. BASE_ADDR and ADDR_MASK are unused, wb_err_o is tied to 0, and the ERR state is absent.

Test Plan:
- Write, DATA_W=32: addr 0x0000_0010, data 0xDEADBEEF, sel 4'b1111 -> cycle 1 has mem_en=1, mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF; wb_ack_o=1 in cycle 2 only.
- Read, MEM_LATENCY=3: RAM returns 0x12345678 at word 4 -> wb_ack_o=1 in cycle 5; wb_data_o=0x12345678; mem_en high in cycle 1 only.
- Byte write: sel 4'b0100, data 0x00AB0000 -> mem_sel_o=4'b0100; the RAM model updates byte 2 only.
- Abort: read with MEM_LATENCY=4, stb dropped in cycle 2 -> no ack; IDLE by cycle 3; wb_data_o unchanged; next request is served normally.
- Error, macro defined: addr 0x0000_2000 with mask 0xFFFF_F000 and base 0 -> wb_err_o=1 in cycle 1; mem_en stays 0; wb_ack_o stays 0.
- Reset mid-read: rst_i=1 in WAIT -> next cycle all outputs at reset values; no ack; wb_data_o=0.
